// File: rtl/iob_ext_mem_arbiter_pkg.sv
// Shared types for the two-master external-memory arbiter: FSM states and master ids.
// Optional read timeout is enabled with IOB_EXT_MEM_ARB_TIMEOUT_EN (see iob_ext_mem_arbiter).
package iob_ext_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    // After an accept the loser gets priority: prio=1 means m0 wins the next tie.
    function automatic logic next_prio(input logic winner);
        return (winner == MST_M1) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/iob_ext_mem_arbiter_rr2.sv
// Two-way round-robin grant; when lock_i is set the current owner is passed straight through.
module iob_rr_arb2
    import iob_ext_mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       prio_i,
    input  logic       lock_i,
    input  logic       owner_i,
    output logic       gnt_o
);

    // Grant selection: sole requester wins, ties go by prio_i.
    always_comb begin
        gnt_o = MST_M1;
        if (lock_i) begin
            gnt_o = owner_i;
        end else begin
            case (req_i)
                2'b01:   gnt_o = MST_M0;
                2'b10:   gnt_o = MST_M1;
                default: gnt_o = prio_i ? MST_M0 : MST_M1;
            endcase
        end
    end

endmodule

// File: rtl/iob_ext_mem_arbiter.sv
// Shares one IOb external-memory port between ibus (m0, read-only) and dbus (m1, read/write).
// Define IOB_EXT_MEM_ARB_TIMEOUT_EN to add the read-response timeout and sticky timeout_o flag.
module iob_ext_mem_arbiter
    import iob_ext_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  m0_avalid_i,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    output logic                  m0_ready_o,
    output logic [DATA_W-1:0]     m0_rdata_o,
    output logic                  m0_rvalid_o,
    input  logic                  m1_avalid_i,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic [DATA_W-1:0]     m1_wdata_i,
    input  logic [DATA_W/8-1:0]   m1_wstrb_i,
    output logic                  m1_ready_o,
    output logic [DATA_W-1:0]     m1_rdata_o,
    output logic                  m1_rvalid_o,
    output logic                  s_avalid_o,
    output logic [ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]     s_wdata_o,
    output logic [DATA_W/8-1:0]   s_wstrb_o,
    input  logic                  s_ready_i,
    input  logic [DATA_W-1:0]     s_rdata_i,
    input  logic                  s_rvalid_i,
    output logic                  timeout_o
);

    arb_state_t state_q, state_d;
    logic       prio_q, prio_d;
    logic       owner_q, owner_d;
    logic       grant_s;
    logic       is_read_s;
    logic       resp_valid_s;
    logic       timeout_hit_s;
    logic       done_s;

    iob_rr_arb2 u_rr (
        .req_i   ({m1_avalid_i, m0_avalid_i}),
        .prio_i  (prio_q),
        .lock_i  (state_q == ST_LOCK),
        .owner_i (owner_q),
        .gnt_o   (grant_s)
    );

    assign is_read_s = (grant_s == MST_M0) || (m1_wstrb_i == {(DATA_W/8){1'b0}});
    assign done_s    = resp_valid_s | timeout_hit_s;

    // Request muxing, response routing and next-state selection.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        s_avalid_o  = 1'b0;
        m0_ready_o  = 1'b0;
        m1_ready_o  = 1'b0;
        s_addr_o    = (grant_s == MST_M1) ? m1_addr_i : m0_addr_i;
        s_wdata_o   = (grant_s == MST_M1) ? m1_wdata_i : {DATA_W{1'b0}};
        s_wstrb_o   = (grant_s == MST_M1) ? m1_wstrb_i : {(DATA_W/8){1'b0}};
        m0_rdata_o  = timeout_hit_s ? {DATA_W{1'b0}} : s_rdata_i;
        m1_rdata_o  = timeout_hit_s ? {DATA_W{1'b0}} : s_rdata_i;
        m0_rvalid_o = done_s & (owner_q == MST_M0);
        m1_rvalid_o = done_s & (owner_q == MST_M1);
        case (state_q)
            ST_IDLE, ST_LOCK: begin
                if (state_q == ST_IDLE) begin
                    s_avalid_o = m0_avalid_i | m1_avalid_i;
                end else begin
                    s_avalid_o = (grant_s == MST_M1) ? m1_avalid_i : m0_avalid_i;
                end
                m0_ready_o = s_avalid_o & s_ready_i & (grant_s == MST_M0);
                m1_ready_o = s_avalid_o & s_ready_i & (grant_s == MST_M1);
                if (s_avalid_o && s_ready_i) begin
                    owner_d = grant_s;
                    prio_d  = next_prio(grant_s);
                    state_d = is_read_s ? ST_RESP : ST_IDLE;
                end else if (s_avalid_o) begin
                    // Memory stalled: freeze the grant so the address cannot change under it.
                    owner_d = grant_s;
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers, frozen while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            owner_q <= MST_M0;
        end else if (cke_i) begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
        end
    end

`ifdef IOB_EXT_MEM_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 drop_q, drop_d;
    logic                 timeout_q, timeout_d;

    // A late response after a forced completion must not be mistaken for the next read's data.
    assign resp_valid_s  = (state_q == ST_RESP) & s_rvalid_i & ~drop_q;
    assign timeout_hit_s = (state_q == ST_RESP) & ~resp_valid_s &
                           (cnt_q == TIMEOUT_W'(TIMEOUT - 1));
    assign timeout_o     = timeout_q;

    // Response-wait counter, drop flag and sticky timeout flag.
    always_comb begin
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        timeout_d = timeout_q;
        if ((state_q != ST_RESP) && (state_d == ST_RESP)) begin
            cnt_d = {TIMEOUT_W{1'b0}};
        end else if (state_q == ST_RESP) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (timeout_hit_s) begin
            drop_d    = 1'b1;
            timeout_d = 1'b1;
        end else if (drop_q && s_rvalid_i) begin
            drop_d = 1'b0;
        end else begin
            drop_d = drop_q;
        end
    end

    // Timeout registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q     <= {TIMEOUT_W{1'b0}};
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else if (cke_i) begin
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic [TIMEOUT_W-1:0] timeout_cfg_unused_s;

    assign resp_valid_s         = (state_q == ST_RESP) & s_rvalid_i;
    assign timeout_hit_s        = 1'b0;
    assign timeout_o            = 1'b0;
    assign timeout_cfg_unused_s = TIMEOUT_W'(TIMEOUT);
`endif

endmodule

// File: tb/tb_iob_ext_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized masters/memory against a transaction-level model.
module tb_iob_ext_mem_arbiter;

    localparam int TB_TIMEOUT = 8;
`ifdef IOB_EXT_MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        cke_i = 1'b1;
    logic        m0_avalid_i = 1'b0;
    logic [31:0] m0_addr_i = 32'h0;
    logic        m0_ready_o;
    logic [31:0] m0_rdata_o;
    logic        m0_rvalid_o;
    logic        m1_avalid_i = 1'b0;
    logic [31:0] m1_addr_i = 32'h0;
    logic [31:0] m1_wdata_i = 32'h0;
    logic [3:0]  m1_wstrb_i = 4'h0;
    logic        m1_ready_o;
    logic [31:0] m1_rdata_o;
    logic        m1_rvalid_o;
    logic        s_avalid_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic        s_ready_i = 1'b0;
    logic [31:0] s_rdata_i = 32'h0;
    logic        s_rvalid_i = 1'b0;
    logic        timeout_o;

    iob_ext_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT_W (16),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cke_i       (cke_i),
        .m0_avalid_i (m0_avalid_i),
        .m0_addr_i   (m0_addr_i),
        .m0_ready_o  (m0_ready_o),
        .m0_rdata_o  (m0_rdata_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m1_avalid_i (m1_avalid_i),
        .m1_addr_i   (m1_addr_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_wstrb_i  (m1_wstrb_i),
        .m1_ready_o  (m1_ready_o),
        .m1_rdata_o  (m1_rdata_o),
        .m1_rvalid_o (m1_rvalid_o),
        .s_avalid_o  (s_avalid_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_wstrb_o   (s_wstrb_o),
        .s_ready_i   (s_ready_i),
        .s_rdata_i   (s_rdata_i),
        .s_rvalid_i  (s_rvalid_i),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns an outstanding read, who holds a stalled request, who wins the next tie.
    int rd_owner;
    int held;
    int favour;
    int age;
    bit drop;
    bit tmo_flag;
    bit acc0;
    bit acc1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        rd_owner = -1;
        held     = -1;
        favour   = 1;
        age      = 0;
        drop     = 1'b0;
        tmo_flag = 1'b0;
        acc0     = 1'b0;
        acc1     = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_s_avalid"}, 32'(s_avalid_o), 32'd0);
        check_eq({tag, "_m0_ready"}, 32'(m0_ready_o), 32'd0);
        check_eq({tag, "_m1_ready"}, 32'(m1_ready_o), 32'd0);
        check_eq({tag, "_m0_rvalid"}, 32'(m0_rvalid_o), 32'd0);
        check_eq({tag, "_m1_rvalid"}, 32'(m1_rvalid_o), 32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    // Called at the negedge: compare every output with the model, then advance the model over the next posedge.
    task automatic eval_cycle();
        logic [1:0] req;
        logic       any;
        logic       is_rd;
        logic       rv_eff;
        logic       hit;
        logic       done;
        int         who;
        req = {m1_avalid_i, m0_avalid_i};
        any = |req;
        if (held >= 0) who = held;
        else if (req == 2'b11) who = favour;
        else who = req[1] ? 1 : 0;
        is_rd  = (who == 0) || (m1_wstrb_i == 4'h0);
        rv_eff = s_rvalid_i && !drop;
        hit    = TMO_EN && (rd_owner >= 0) && (age == TB_TIMEOUT - 1) && !rv_eff;
        done   = (rd_owner >= 0) && (rv_eff || hit);
        check_eq("timeout_o", 32'(timeout_o), 32'(tmo_flag));
        check_eq("m0_rvalid", 32'(m0_rvalid_o), 32'(done && rd_owner == 0));
        check_eq("m1_rvalid", 32'(m1_rvalid_o), 32'(done && rd_owner == 1));
        if (rd_owner >= 0) begin
            check_eq("resp_s_avalid", 32'(s_avalid_o), 32'd0);
            check_eq("resp_m0_ready", 32'(m0_ready_o), 32'd0);
            check_eq("resp_m1_ready", 32'(m1_ready_o), 32'd0);
            check_eq("m0_rdata", m0_rdata_o, hit ? 32'h0 : s_rdata_i);
            check_eq("m1_rdata", m1_rdata_o, hit ? 32'h0 : s_rdata_i);
        end else begin
            check_eq("s_avalid", 32'(s_avalid_o), 32'(any));
            check_eq("m0_ready", 32'(m0_ready_o), 32'(any && who == 0 && s_ready_i));
            check_eq("m1_ready", 32'(m1_ready_o), 32'(any && who == 1 && s_ready_i));
            if (any) begin
                check_eq("s_addr", s_addr_o, (who == 1) ? m1_addr_i : m0_addr_i);
                check_eq("s_wstrb", 32'(s_wstrb_o), (who == 1) ? 32'(m1_wstrb_i) : 32'd0);
                if (who == 1) check_eq("s_wdata", s_wdata_o, m1_wdata_i);
            end
        end
        acc0 = m0_ready_o;
        acc1 = m1_ready_o;
        if (cke_i) begin
            if (rd_owner >= 0) begin
                if (done) rd_owner = -1;
                else age++;
            end else if (any && s_ready_i) begin
                favour = 1 - who;
                held   = -1;
                if (is_rd) begin
                    rd_owner = who;
                    age      = 0;
                end
            end else if (any) begin
                held = who;
            end
            if (hit) begin
                drop     = 1'b1;
                tmo_flag = 1'b1;
            end else if (drop && s_rvalid_i) begin
                drop = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        m0_avalid_i = 1'b0;
        m1_avalid_i = 1'b0;
        s_ready_i   = 1'b0;
        s_rvalid_i  = 1'b1;
        cke_i       = 1'b1;
        arst_n_i    = 1'b0;
        #1;
        model_reset();
        check_quiet("reset");
        @(negedge clk_i);
        arst_n_i   = 1'b1;
        s_rvalid_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk_i);
        #1;
        apply_reset();

        // Contention: m1 wins the first tie, m0 next, and a 5-cycle read returns only to m0.
        m0_avalid_i = 1'b1; m0_addr_i = 32'h100;
        m1_avalid_i = 1'b1; m1_addr_i = 32'h200; m1_wstrb_i = 4'h0;
        s_ready_i   = 1'b1;
        @(negedge clk_i);
        check_eq("tie_first_m1", 32'(m1_ready_o), 32'd1);
        check_eq("tie_first_addr", s_addr_o, 32'h200);
        eval_cycle();
        m1_avalid_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        check_eq("m1_read_rvalid", 32'(m1_rvalid_o), 32'd1);
        eval_cycle();
        s_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("rr_m0_next", 32'(m0_ready_o), 32'd1);
        eval_cycle();
        m0_avalid_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE_F00D;
                m0_avalid_i = 1'b1; m0_addr_i = 32'h104;
                m1_avalid_i = 1'b1; m1_addr_i = 32'h204;
            end
            @(negedge clk_i);
            if (k == 5) begin
                check_eq("rd_ret_m0_rvalid", 32'(m0_rvalid_o), 32'd1);
                check_eq("rd_ret_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
                check_eq("rd_ret_data", m0_rdata_o, 32'hCAFE_F00D);
                check_eq("bubble_m1_ready", 32'(m1_ready_o), 32'd0);
            end
            eval_cycle();
        end
        s_rvalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("tie_again_m1", 32'(m1_ready_o), 32'd1);
        eval_cycle();
        m1_avalid_i = 1'b0; m0_avalid_i = 1'b0; s_rvalid_i = 1'b1;
        @(negedge clk_i);
        eval_cycle();
        s_rvalid_i = 1'b0;

        // Back-pressure: stalled m1 write keeps the port while m0 waits.
        m1_avalid_i = 1'b1; m1_addr_i = 32'h300; m1_wdata_i = 32'hA5A5_0001; m1_wstrb_i = 4'hF;
        s_ready_i   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                m0_avalid_i = 1'b1; m0_addr_i = 32'h400;
            end
            @(negedge clk_i);
            check_eq("bp_addr", s_addr_o, 32'h300);
            check_eq("bp_m0_ready", 32'(m0_ready_o), 32'd0);
            eval_cycle();
        end
        s_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("bp_accept_m1", 32'(m1_ready_o), 32'd1);
        eval_cycle();
        m1_avalid_i = 1'b0;
        @(negedge clk_i);
        check_eq("bp_then_m0", 32'(m0_ready_o), 32'd1);
        eval_cycle();
        m0_avalid_i = 1'b0; s_rvalid_i = 1'b1;
        @(negedge clk_i);
        eval_cycle();
        s_rvalid_i = 1'b0;

        // Back-to-back writes: one accept per cycle, never entering RESP.
        for (int k = 0; k < 4; k++) begin
            m1_avalid_i = 1'b1; m1_addr_i = 32'h500 + 32'(k * 4);
            m1_wdata_i  = $urandom; m1_wstrb_i = 4'hF;
            @(negedge clk_i);
            check_eq("wr_b2b_ready", 32'(m1_ready_o), 32'd1);
            eval_cycle();
        end
        m1_avalid_i = 1'b0;

`ifdef IOB_EXT_MEM_ARB_TIMEOUT_EN
        // Timeout: read never answered, forced completion on the TIMEOUT-th RESP cycle.
        m0_avalid_i = 1'b1; m0_addr_i = 32'h600; s_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        eval_cycle();
        m0_avalid_i = 1'b0;
        for (int k = 1; k <= TB_TIMEOUT; k++) begin
            @(negedge clk_i);
            check_eq("tmo_rvalid", 32'(m0_rvalid_o), 32'(k == TB_TIMEOUT));
            eval_cycle();
        end
        @(negedge clk_i);
        check_eq("tmo_flag", 32'(timeout_o), 32'd1);
        eval_cycle();
        m0_avalid_i = 1'b1; m0_addr_i = 32'h604; s_rvalid_i = 1'b0;
        @(negedge clk_i);
        eval_cycle();
        m0_avalid_i = 1'b0; s_rvalid_i = 1'b1;
        @(negedge clk_i);
        check_eq("tmo_late_dropped", 32'(m0_rvalid_o), 32'd0);
        eval_cycle();
        @(negedge clk_i);
        check_eq("tmo_next_rvalid", 32'(m0_rvalid_o), 32'd1);
        eval_cycle();
        s_rvalid_i = 1'b0;
`endif

        // Randomized masters and memory, including clock-enable gaps and stray rvalids.
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (acc0) m0_avalid_i = 1'b0;
            if (acc1) m1_avalid_i = 1'b0;
            if (!m0_avalid_i && $urandom_range(0, 2) == 0) begin
                m0_avalid_i = 1'b1; m0_addr_i = $urandom;
            end
            if (!m1_avalid_i && $urandom_range(0, 2) == 0) begin
                m1_avalid_i = 1'b1; m1_addr_i = $urandom; m1_wdata_i = $urandom;
                m1_wstrb_i  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            cke_i      = ($urandom_range(0, 9) != 0);
            s_ready_i  = cke_i && ($urandom_range(0, 3) != 0);
            s_rvalid_i = cke_i && ($urandom_range(0, 2) == 0);
            s_rdata_i  = $urandom;
            @(negedge clk_i);
            eval_cycle();
        end
        cke_i = 1'b1;

        // Reset while a read is outstanding: response is lost, m1 priority restored.
        m0_avalid_i = 1'b0; m1_avalid_i = 1'b0; s_rvalid_i = 1'b0; s_ready_i = 1'b0;
        for (int k = 0; k < 40 && rd_owner >= 0; k++) begin
            s_rvalid_i = 1'b1;
            @(negedge clk_i);
            eval_cycle();
        end
        s_rvalid_i = 1'b0;
        m0_avalid_i = 1'b1; m0_addr_i = 32'h700; s_ready_i = 1'b1;
        @(negedge clk_i);
        eval_cycle();
        m0_avalid_i = 1'b0; s_ready_i = 1'b0;
        @(negedge clk_i);
        check_eq("pre_reset_in_resp", 32'(rd_owner), 32'd0);
        eval_cycle();
        apply_reset();
        m0_avalid_i = 1'b1; m0_addr_i = 32'h800;
        m1_avalid_i = 1'b1; m1_addr_i = 32'h900; m1_wstrb_i = 4'h0;
        s_ready_i   = 1'b1;
        @(negedge clk_i);
        check_eq("post_reset_m1_prio", 32'(m1_ready_o), 32'd1);
        eval_cycle();
        m1_avalid_i = 1'b0; m0_avalid_i = 1'b0; s_rvalid_i = 1'b1;
        @(negedge clk_i);
        eval_cycle();
        s_rvalid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
